rf_wport_arb: RTL
=================

// Module: rf_wport_arb
// PURPOSE
//  Shares the register file's single write port among NREQ writeback requesters (ALU, LD/ST, MUL).
//  Sits between execute/memory writeback and the register file.
//  Registers one granted write per cycle onto rf_we/rf_ws/rf_wd and diverts R15 writes to the PC-write port.
//  Flags read-after-write hazards caused by the register file's synchronous read of the old value.
// PARAMETERS
//  NREQ            3   number of writeback requesters (2..8)
//  REG_WIDTH       32  data width
//  REG_ADDR_WIDTH  4   register index width; index 15 = PC
// PORTS
//  clk        in   1                    clock; all logic on posedge
//  resetn     in   1                    synchronous, active-low reset
//  wb_stall   in   1                    pipeline freeze; no grants while high
//  req_valid  in   NREQ                 requester i has a write pending
//  req_ready  out  NREQ                 grant; one-hot or zero, combinational
//  req_ws     in   NREQ*REG_ADDR_WIDTH  dest index, slice i = [i*RAW +: RAW]
//  req_wd     in   NREQ*REG_WIDTH       write data, slice i = [i*RW +: RW]
//  rd_rs1     in   REG_ADDR_WIDTH       read addr 1 presented to regfile this cycle
//  rd_rs2     in   REG_ADDR_WIDTH       read addr 2 presented to regfile this cycle
//  rf_we      out  1                    regfile write enable (registered)
//  rf_ws      out  REG_ADDR_WIDTH       regfile write address (registered)
//  rf_wd      out  REG_WIDTH            regfile write data (registered)
//  pc_we      out  1                    PC write strobe for dest 15 (registered)
//  pc_wd      out  REG_WIDTH            PC write data (registered)
//  hz1, hz2   out  1                    rd_rs1/rd_rs2 collide with the write committing this cycle
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): rf_we=0, pc_we=0, rf_ws=0, rf_wd=0, pc_wd=0, RR pointer=0.
//    While resetn=0, req_ready=0 and hz1=hz2=0. Reset mid-transfer drops the registered write.
//  - Transfer on requester i = req_valid[i] && req_ready[i]. A requester holds valid/ws/wd stable until granted.
//  - Grant is combinational from req_valid, pointer and wb_stall; at most one bit set. wb_stall=1 -> req_ready=0.
//  - Latency: transfer in cycle N -> output stage loaded at posedge ending N; rf_we or pc_we high during N+1.
//  - Dest != 15: rf_we=1, rf_ws=ws, rf_wd=wd, pc_we=0. Dest == 15: pc_we=1, pc_wd=wd, rf_we=0.
//  - No transfer in a cycle -> rf_we=0, pc_we=0 next cycle; rf_ws/rf_wd/pc_wd hold their last values.
//  - hz1 = rf_we && (rd_rs1 == rf_ws) && (rd_rs1 != 15); hz2 likewise. Purely combinational.
//    Consumer re-issues the read or forwards rf_wd.
//  - No backpressure from the regfile: the output stage accepts every cycle and has no FIFO.
//  - Back-to-back grants to the same requester are allowed; throughput is 1 write/cycle.
//  - Same dest from two requesters: serialized in grant order; the later grant wins in the regfile.
// CONFIGURATION
//  RF_RR_ARB_EN defined  : round-robin. After a grant to i, the pointer moves to i+1 mod NREQ.
//                          Search starts at the pointer. Pointer holds when there is no grant.
//  RF_RR_ARB_EN undefined: fixed priority, index 0 highest. No pointer state.
// STRUCTURE
//  Shared package rf_pkg: REG_WIDTH, REG_ADDR_WIDTH, NREG=16, PC_IDX=4'hF, and the rf_wr_t struct {we, ws, wd}.
//  One sub-module: rf_rr_grant (NREQ-wide grant logic, with pointer register when RF_RR_ARB_EN is defined).
//  Top level owns the output stage, the PC divert and hazard compare.
// TESTING
//  1. resetn=0 for 2 cycles with req_valid=3'b111 -> req_ready=0, rf_we=0, pc_we=0. After release, the first grant is to req 0.
//  2. Only req1 valid, ws=3, wd=32'hDEAD_BEEF at cycle N -> req_ready=3'b010. Cycle N+1: rf_we=1, rf_ws=3, rf_wd=DEADBEEF.
//  3. req0 ws=15, wd=32'h0000_0100 -> next cycle pc_we=1, pc_wd=0x100, rf_we=0.
//  4. All three valid for 6 cycles, RF_RR_ARB_EN defined -> grant order 0,1,2,0,1,2.
//     Same stimulus without the macro -> six grants to req 0.
//  5. wb_stall=1 for 3 cycles with req2 valid -> no grant, rf_we=0. Grant to req2 in the cycle wb_stall drops.
//  6. rf_we=1, rf_ws=5; rd_rs1=5, rd_rs2=6 -> hz1=1, hz2=0. With rf_ws=15 held, rd_rs1=15 -> hz1=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Used by rf_rr_grant and rf_wport_arb.
package rf_pkg;
  localparam int REG_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 4;
  localparam int NREG           = 16;
  localparam logic [REG_ADDR_WIDTH-1:0] PC_IDX = 4'hF;

  typedef struct packed {
    logic                      we;
    logic [REG_ADDR_WIDTH-1:0] ws;
    logic [REG_WIDTH-1:0]      wd;
  } rf_wr_t;
endpackage

// File: rtl/rf_rr_grant.sv
// One-hot grant for the write-port requesters.
// RF_RR_ARB_EN selects round-robin with a pointer; otherwise index 0 wins.
module rf_rr_grant #(
  parameter int NREQ = 3
) (
`ifdef RF_RR_ARB_EN
  input  logic            clk,
`endif
  input  logic            resetn,
  input  logic            stall,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] grant
);

`ifdef RF_RR_ARB_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
      end
    end
    if (!resetn || stall) begin
      grant = '0;
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
      end
    end
    if (!resetn || stall) grant = '0;
  end
`endif

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: grant, registered write, PC divert, RAW hazard flags.
// Arbitration policy set by RF_RR_ARB_EN (round-robin) or its absence (fixed priority).
module rf_wport_arb #(
  parameter int NREQ           = 3,
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           wb_stall,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ*REG_ADDR_WIDTH-1:0] req_ws,
  input  logic [NREQ*REG_WIDTH-1:0]      req_wd,
  input  logic [REG_ADDR_WIDTH-1:0]      rd_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]      rd_rs2,
  output logic                           rf_we,
  output logic [REG_ADDR_WIDTH-1:0]      rf_ws,
  output logic [REG_WIDTH-1:0]           rf_wd,
  output logic                           pc_we,
  output logic [REG_WIDTH-1:0]           pc_wd,
  output logic                           hz1,
  output logic                           hz2
);
  import rf_pkg::*;

  rf_wr_t                      wr_q, wr_d;
  logic                        pc_we_q, pc_we_d;
  logic [REG_WIDTH-1:0]        pc_wd_q, pc_wd_d;
  logic [REG_ADDR_WIDTH-1:0]   sel_ws;
  logic [REG_WIDTH-1:0]        sel_wd;
  logic                        xfer;

  rf_rr_grant #(.NREQ(NREQ)) u_grant (
`ifdef RF_RR_ARB_EN
    .clk       (clk),
`endif
    .resetn    (resetn),
    .stall     (wb_stall),
    .req_valid (req_valid),
    .grant     (req_ready)
  );

  always_comb begin
    sel_ws = '0;
    sel_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_ws = req_ws[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        sel_wd = req_wd[i*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  assign xfer = |(req_valid & req_ready);

  // Writes to the PC index never touch the regfile port.
  always_comb begin
    wr_d    = wr_q;
    wr_d.we = 1'b0;
    pc_we_d = 1'b0;
    pc_wd_d = pc_wd_q;
    if (xfer) begin
      if (sel_ws == PC_IDX) begin
        pc_we_d = 1'b1;
        pc_wd_d = sel_wd;
      end else begin
        wr_d.we = 1'b1;
        wr_d.ws = sel_ws;
        wr_d.wd = sel_wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q    <= '0;
      pc_we_q <= 1'b0;
      pc_wd_q <= '0;
    end else begin
      wr_q    <= wr_d;
      pc_we_q <= pc_we_d;
      pc_wd_q <= pc_wd_d;
    end
  end

  assign rf_we = wr_q.we;
  assign rf_ws = wr_q.ws;
  assign rf_wd = wr_q.wd;
  assign pc_we = pc_we_q;
  assign pc_wd = pc_wd_q;

  assign hz1 = resetn && wr_q.we && (rd_rs1 == wr_q.ws) && (rd_rs1 != PC_IDX);
  assign hz2 = resetn && wr_q.we && (rd_rs2 == wr_q.ws) && (rd_rs2 != PC_IDX);

endmodule
